// File: rtl/disp_scan.sv
// disp_scan: binary-to-BCD conversion and multiplexed seven-segment scan.
//
// A sequential double-dabble engine converts bin_in into packed BCD. The
// result is committed to a display register in a single step. A free-running
// prescaler then time-multiplexes the committed digits onto disp_num and
// drives active-low digit enables, with leading-zero blanking.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   rst_n     in   1       synchronous active-low reset
//   bin_in    in   WIDTH   unsigned value; sampled when a load is accepted
//   load      in   1       conversion request (ignored while converting)
//   busy      out  1       conversion in progress
//   done      out  1       one-cycle pulse when new digits are committed
//   disp_num  out  4       BCD digit of the currently scanned position
//   digit_en  out  DIGITS  active-low digit enables, at most one bit low
module disp_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  bin_in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [3:0]        disp_num,
  output logic [DIGITS-1:0] digit_en
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // ---------------------------------------------------------------------------
  // Conversion engine
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] disp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                    ? scratch_q[4*gi +: 4] + 4'd3
                                    : scratch_q[4*gi +: 4];
  end

  // The scratch and the binary shift register shift as one long word.
  assign {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          disp_q <= scratch_q;
          done_q <= 1'b1;
          // busy falls on this edge, so a request arriving here already
          // starts the next conversion back-to-back.
          if (load) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]  presc_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        disp_num_q, disp_num_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic [DIGITS-1:0] zero_from;
  logic              blank_d;

  // zero_from[i]: display digits i..DIGITS-1 are all zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
    assign zero_from[gi] = (disp_q[BCD_W-1:4*gi] == '0);
  end

  assign idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

  // Outputs are precomputed for the index about to become current, so that
  // index, digit and enable all change on the same edge.
  always_comb begin
    blank_d    = (idx_d != '0) && zero_from[idx_d];
    disp_num_d = 4'd0;
    digit_en_d = '1;
    if (!blank_d) begin
      disp_num_d        = disp_q[4*idx_d +: 4];
      digit_en_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      disp_num_q <= 4'd0;
      digit_en_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_q    <= '0;
      idx_q      <= idx_d;
      disp_num_q <= disp_num_d;
      digit_en_q <= digit_en_d;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign disp_num = disp_num_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_disp_scan.sv
// Testbench for disp_scan: directed scenarios followed by random load/reset
// traffic, each cycle compared against a value-level reference model.
module tb_disp_scan;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] bin_in = '0;
  logic         busy;
  logic         done;
  logic [3:0]   disp_num;
  logic [D-1:0] digit_en;

  always #5 clk = ~clk;

  disp_scan #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bin_in   (bin_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .disp_num (disp_num),
    .digit_en (digit_en)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: conversion is a countdown to the commit edge, digits
  // come from decimal arithmetic on the committed value.
  bit conv_active;
  int conv_val;
  int conv_left;
  int m_disp;
  bit m_busy;
  bit m_done;
  int m_presc;
  int m_idx;
  int m_num;
  int m_en;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  task automatic model_update(input bit r, input bit ld, input int v);
    int  old_disp;
    bit  commit_now;
    bit  can_accept;
    bit  blank;
    if (!r) begin
      conv_active = 0;
      conv_left   = 0;
      m_disp      = 0;
      m_busy      = 0;
      m_done      = 0;
      m_presc     = 0;
      m_idx       = 0;
      m_num       = 0;
      m_en        = (1 << D) - 2;
    end else begin
      old_disp   = m_disp;
      commit_now = conv_active && (conv_left == 1);
      can_accept = !conv_active || commit_now;
      m_done     = 0;
      if (conv_active) begin
        conv_left--;
        if (conv_left == 0) begin
          m_disp      = conv_val;
          m_done      = 1;
          conv_active = 0;
        end
      end
      if (ld && can_accept) begin
        conv_active = 1;
        conv_val    = v;
        conv_left   = W + 1;
      end
      m_busy = conv_active;
      if (m_presc == SD - 1) begin
        m_presc = 0;
        m_idx   = (m_idx + 1) % D;
        blank   = (m_idx > 0) && (old_disp < pow10(m_idx));
        m_num   = blank ? 0 : (old_disp / pow10(m_idx)) % 10;
        m_en    = blank ? (1 << D) - 1 : ((1 << D) - 1) & ~(1 << m_idx);
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic step(input bit r, input bit ld, input int v);
    rst_n  = r;
    load   = ld;
    bin_in = W'(v);
    @(posedge clk);
    cyc++;
    model_update(r, ld, v);
    #1;
    check_value("busy", 32'(busy), 32'(m_busy));
    check_value("done", 32'(done), 32'(m_done));
    check_value("disp_num", 32'(disp_num), 32'(m_num));
    check_value("digit_en", 32'(digit_en), 32'(m_en));
    if (m_done) $display("cycle %0d: commit value %0d", cyc, m_disp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, $urandom_range(0, 255));
  endtask

  initial begin
    // Reset, then an empty display: single "0" in slot 0.
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    idle(16);

    // Full-scale, small and inner-zero values.
    step(1, 1, 255); idle(30);
    step(1, 1, 7);   idle(30);
    step(1, 1, 100); idle(30);

    // Request during conversion is dropped; one at the commit edge is taken.
    step(1, 1, 200); idle(2);
    step(1, 1, 55);  idle(5);
    step(1, 1, 55);  idle(30);

    // Reset mid-conversion aborts it; a fresh request converts normally.
    step(1, 1, 123); idle(3);
    step(0, 0, 0);   idle(14);
    step(1, 1, 123); idle(30);

    // Random traffic, biased toward small values to exercise blanking.
    for (int i = 0; i < 600; i++) begin
      int sel;
      int v;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 99);
        default: v = $urandom_range(0, 255);
      endcase
      step($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0, v);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
# disp_scan

Upstream stage of the calculator's seven-segment path. Converts a binary result to packed BCD with a sequential double-dabble engine. Holds the converted digits in a display register and time-multiplexes them onto a single 4-bit `disp_num` bus, which feeds the segment decoder. It drives active-low digit enables in step with that bus, with leading-zero blanking.

## Interface
- `WIDTH`, 8, width of the binary input value.
- `DIGITS`, 3, number of BCD digits and physical digits; integrator guarantees 10^DIGITS > 2^WIDTH-1.
- `SCAN_DIV`, 50000, clock cycles each digit stays active; minimum 2.
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `bin_in`  in  WIDTH  unsigned value to display; sampled only on an accepted `load`.
- `load`  in  1  conversion request; accepted only when `busy`=0.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when the new digits are committed to the display register.
- `disp_num`  out  4  BCD digit for the currently scanned position, to the segment decoder.
- `digit_en`  out  DIGITS  active-low digit enables; at most one bit low.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - `load`=1 latches `bin_in` into the shift register, clears the BCD scratch, clears the bit counter, and moves to SHIFT.
  - `load`=0 stays in IDLE.
- SHIFT: each cycle, every scratch nibble ≥5 gets +3. The combined {scratch, shift reg} then shifts left by 1 in the same cycle. The counter increments. After the WIDTH-th shift, go to COMMIT.
- COMMIT: copy the scratch into the display register (all digits at once), pulse `done`, return to IDLE.
- `load` while `busy`=1 is ignored, not queued. `bin_in` changes during conversion have no effect.
- Display register changes only in COMMIT. The scan never shows a partially converted value.
- Scan prescaler counts 0..SCAN_DIV-1 continuously. It runs independently of the FSM.
- On prescaler wrap, the digit index advances 0→1→…→DIGITS-1→0. Index 0 is the least-significant digit.
- `disp_num` and `digit_en` are registered. Both update on the same edge as the index, so they are always consistent.
- `digit_en` drives bit[idx] low and all others high.
- Blanking:
  - Digit i>0 is blanked when display digits i..DIGITS-1 are all zero.
  - A blanked slot drives `digit_en` all ones and `disp_num`=0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- `disp_num` is always 0–9, never an undefined code.

## Timing
- Reset values, applied on any edge with `rst_n`=0 and overriding everything:
  - `busy`=0, `done`=0, `disp_num`=0.
  - `digit_en` = all ones except bit0=0.
  - Display register=0, FSM=IDLE, prescaler=0, index=0.
- Reset mid-conversion aborts the conversion. The display stays 0 afterwards.
- `load` is sampled at edge T:
  - `busy`=1 from T to T+WIDTH+1.
  - SHIFT occupies edges T+1..T+WIDTH.
  - COMMIT happens at edge T+WIDTH+1: display register updated and `done`=1 for that cycle.
  - `busy`=0 at edge T+WIDTH+1, so a new `load` is accepted at edge T+WIDTH+1 at the earliest.
- Total latency from `load` to `done` is WIDTH+1 cycles: 9 with defaults.
- New digits appear on `disp_num` at the next scan-slot edge after commit, not mid-slot.
- Each digit slot lasts exactly SCAN_DIV cycles. A full frame is DIGITS×SCAN_DIV cycles.
- Reset and `load` in the same cycle: reset wins.

## Test plan
- Reset, then release with SCAN_DIV=4 → `disp_num`=0 throughout. `digit_en` is 110 for 4 cycles, then 111, 111 (blanked), repeating. `busy`=0.
- `load` with `bin_in`=8'd255 → `busy` high for 9 cycles, `done` pulse at load+9, display 2/5/5. Scan shows `disp_num` 5,5,2 with `digit_en` 110,101,011.
- `bin_in`=8'd7 → digit0=7 with 110; slots 1 and 2 show `digit_en`=111 and `disp_num`=0.
- `bin_in`=8'd100 → digits 0,0,1, none blanked: middle zero shown with `digit_en`=101.
- `load`=200 and again at load+3 with 55 → second request ignored. `done` pulses once, display shows 200. A `load` at load+9 with 55 is accepted and shows 55 after its `done`.
- Deassert `rst_n` at load+4 during a conversion of 123 → no `done`, display 0, `busy`=0 next cycle. A post-reset `load` of 123 converts correctly.
